// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU package: stall-bit positions, stall vector constants,
// pipeline control state type and the default exception vector.
package pipe_ctrl_pkg;

  // Bit positions inside the stall vector
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Holding a stage also holds everything upstream of it, so every stall
  // vector is a contiguous run of ones from the PC up to the requesting stage.
  function automatic logic [STALL_WB:0] stall_upto(input int idx);
    logic [STALL_WB:0] m;
    m = '0;
    for (int i = STALL_PC; i <= STALL_WB; i++) begin
      if (i <= idx) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STALL_WB:0] STALL_NONE     = '0;
  localparam logic [STALL_WB:0] STALL_FROM_ID  = stall_upto(STALL_ID);
  localparam logic [STALL_WB:0] STALL_FROM_EX  = stall_upto(STALL_EX);
  localparam logic [STALL_WB:0] STALL_FROM_MEM = stall_upto(STALL_MEM);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MDU   = 2'd1,
    FLUSH = 2'd2
  } pipe_ctrl_state_t;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline
// control unit: stage requests in one direction, hold/flush out the other.
interface pipe_ctrl_if;
  logic        stallreq_id;
  logic        ex_mdu_start;
  logic        stallreq_mem;
  logic        mem_excp;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        mdu_busy;
  logic        mdu_done;

  // Pipeline side: raises requests, obeys stall/flush
  modport master (
    output stallreq_id, ex_mdu_start, stallreq_mem, mem_excp,
    input  stall, flush, new_pc, mdu_busy, mdu_done
  );

  // Controller side
  modport slave (
    input  stallreq_id, ex_mdu_start, stallreq_mem, mem_excp,
    output stall, flush, new_pc, mdu_busy, mdu_done
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage MIPS core: arbitrates stall
// requests, sequences multi-cycle MDU operations and flushes on MEM
// exceptions. Control outputs are combinational so hazards are answered
// in the cycle they are raised.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          DIV_CYCLES = 34,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  localparam int               CNT_W    = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

  pipe_ctrl_state_t   r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_ex_stall;
  logic [5:0]         w_stall;
  logic               w_flush;
  logic               w_busy;
  logic               w_done;

  // Output decode: priority arbitration of stall sources; everything forced
  // low while reset is held, and FLUSH ignores requests from squashed bubbles.
  always_comb begin
    w_stall    = STALL_NONE;
    w_flush    = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_ex_stall = ((r_state == MDU) && (r_cnt != '0)) ||
                 ((r_state == RUN) && bus.ex_mdu_start);
    if (!rst) begin
      if (r_state == FLUSH) begin
        w_flush = bus.mem_excp;
      end else begin
        if (bus.mem_excp)          w_flush = 1'b1;
        else if (bus.stallreq_mem) w_stall = STALL_FROM_MEM;
        else if (w_ex_stall)       w_stall = STALL_FROM_EX;
        else if (bus.stallreq_id)  w_stall = STALL_FROM_ID;
        // An exception aborts the MDU sequence in the same cycle
        if ((r_state == MDU) && !bus.mem_excp) begin
          w_busy = 1'b1;
          w_done = (r_cnt == '0);
        end
      end
    end
  end

  assign bus.stall    = w_stall;
  assign bus.flush    = w_flush;
  assign bus.new_pc   = w_flush ? EXC_VECTOR : '0;
  assign bus.mdu_busy = w_busy;
  assign bus.mdu_done = w_done;

  // Control FSM with inline MDU down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.mem_excp) begin
            r_state <= FLUSH;
          end else if (bus.ex_mdu_start) begin
            r_state <= MDU;
            r_cnt   <= CNT_LOAD;
          end
        end
        MDU: begin
          if (bus.mem_excp) begin
            r_state <= FLUSH;
            r_cnt   <= '0;
          end else if (r_cnt != '0) begin
            // Counting continues even while MEM holds the pipe
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (!bus.stallreq_mem) begin
            r_state <= RUN;
          end
        end
        FLUSH: begin
          if (!bus.mem_excp) r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed per-cycle vectors push their expected
// outputs into a scoreboard queue; an independent monitor pops and
// compares on the falling edge.
module tb_pipe_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;

  pipe_ctrl_if u_if();

  pipe_ctrl #(
    .DIV_CYCLES (34),
    .EXC_VECTOR (32'h0000_0020)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: one comparison per queued expectation, sampled mid-cycle
  always @(negedge clk) begin
    exp_t  e;
    exp_t  g;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = '{stall: u_if.stall, flush: u_if.flush, pc: u_if.new_pc,
             busy: u_if.mdu_busy, done: u_if.mdu_done};
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL %s: got stall=%h flush=%b pc=%h busy=%b done=%b, want stall=%h flush=%b pc=%h busy=%b done=%b",
                 nm, g.stall, g.flush, g.pc, g.busy, g.done,
                 e.stall, e.flush, e.pc, e.busy, e.done);
      end
    end
  end

  // One clock cycle: drive inputs just after the edge, queue the expectation
  task automatic cyc(input string nm, input logic r, input logic id, input logic st,
                     input logic mm, input logic ex, input logic [5:0] es,
                     input logic ef, input logic eb, input logic ed);
    exp_t e;
    @(posedge clk);
    #1;
    rst               = r;
    u_if.stallreq_id  = id;
    u_if.ex_mdu_start = st;
    u_if.stallreq_mem = mm;
    u_if.mem_excp     = ex;
    e.stall = es;
    e.flush = ef;
    e.pc    = ef ? 32'h0000_0020 : 32'h0;
    e.busy  = eb;
    e.done  = ed;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    u_if.stallreq_id  = 1'b0;
    u_if.ex_mdu_start = 1'b0;
    u_if.stallreq_mem = 1'b0;
    u_if.mem_excp     = 1'b0;

    // Reset: outputs quiet even with every request raised
    cyc("rst_all_req", 1, 1, 1, 1, 1, 6'h00, 0, 0, 0);
    cyc("rst_hold",    1, 0, 0, 0, 1, 6'h00, 0, 0, 0);
    cyc("idle",        0, 0, 0, 0, 0, 6'h00, 0, 0, 0);

    // Priority among plain stall requests
    cyc("id_only",     0, 1, 0, 0, 0, 6'h07, 0, 0, 0);
    cyc("id_and_mem",  0, 1, 0, 1, 0, 6'h1F, 0, 0, 0);
    cyc("mem_only",    0, 0, 0, 1, 0, 6'h1F, 0, 0, 0);
    cyc("idle2",       0, 0, 0, 0, 0, 6'h00, 0, 0, 0);

    // Full MDU timeline; ID request and repeated start inside are dominated/ignored
    cyc("mdu_start",   0, 0, 1, 0, 0, 6'h0F, 0, 0, 0);
    for (int i = 1; i <= 33; i++) begin
      if (i == 5)       cyc("mdu_id_in_ex",  0, 1, 0, 0, 0, 6'h0F, 0, 1, 0);
      else if (i == 8)  cyc("mdu_restart",   0, 0, 1, 0, 0, 6'h0F, 0, 1, 0);
      else              cyc("mdu_count",     0, 0, 0, 0, 0, 6'h0F, 0, 1, 0);
    end
    cyc("mdu_done",    0, 0, 0, 0, 0, 6'h00, 0, 1, 1);
    cyc("mdu_back_run",0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("run_id",      0, 1, 0, 0, 0, 6'h07, 0, 0, 0);

    // MDU ending under a MEM stall; counter keeps running under MEM stall too
    cyc("mdu2_start",  0, 0, 1, 1, 0, 6'h1F, 0, 0, 0);
    for (int i = 1; i <= 33; i++) begin
      if (i == 10) cyc("mdu2_mem_mid", 0, 0, 0, 1, 0, 6'h1F, 0, 1, 0);
      else         cyc("mdu2_count",   0, 0, 0, 0, 0, 6'h0F, 0, 1, 0);
    end
    for (int i = 0; i < 3; i++)
      cyc("mdu2_done_mem", 0, 0, 0, 1, 0, 6'h1F, 0, 1, 1);
    cyc("mdu2_done_last", 0, 0, 0, 0, 0, 6'h00, 0, 1, 1);
    cyc("mdu2_back_run",  0, 0, 0, 0, 0, 6'h00, 0, 0, 0);

    // Exception at cnt=5 aborts the sequence; FLUSH ignores requests
    cyc("mdu3_start",  0, 0, 1, 0, 0, 6'h0F, 0, 0, 0);
    for (int i = 1; i <= 28; i++)
      cyc("mdu3_count", 0, 0, 0, 0, 0, 6'h0F, 0, 1, 0);
    cyc("mdu3_excp",   0, 1, 0, 0, 1, 6'h00, 1, 0, 0);
    cyc("flush_ignore",0, 1, 1, 1, 0, 6'h00, 0, 0, 0);
    cyc("after_flush", 0, 1, 0, 0, 0, 6'h07, 0, 0, 0);

    // Exception repeated while in FLUSH is honoured
    cyc("excp_a",      0, 0, 0, 0, 1, 6'h00, 1, 0, 0);
    cyc("excp_again",  0, 1, 0, 0, 1, 6'h00, 1, 0, 0);
    cyc("flush_end",   0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("run_id2",     0, 1, 0, 0, 0, 6'h07, 0, 0, 0);

    // Exception beats a simultaneous MDU start
    cyc("excp_vs_start", 0, 0, 1, 0, 1, 6'h00, 1, 0, 0);
    cyc("no_mdu_flush",  0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("no_mdu_run",    0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("no_mdu_id",     0, 1, 0, 0, 0, 6'h07, 0, 0, 0);

    // Reset mid-MDU at cnt=10: no done pulse afterwards
    cyc("mdu4_start",  0, 0, 1, 0, 0, 6'h0F, 0, 0, 0);
    for (int i = 1; i <= 23; i++)
      cyc("mdu4_count", 0, 0, 0, 0, 0, 6'h0F, 0, 1, 0);
    cyc("mdu4_rst",    1, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("mdu4_rst2",   1, 1, 0, 1, 0, 6'h00, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      cyc("post_rst_idle", 0, 0, 0, 0, 0, 6'h00, 0, 0, 0);
    cyc("post_rst_id", 0, 1, 0, 0, 0, 6'h07, 0, 0, 0);
    cyc("final_idle",  0, 0, 0, 0, 0, 6'h00, 0, 0, 0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. Arbitrates stall requests from ID, EX and MEM, sequences multi-cycle multiply/divide operations with an internal cycle counter, and flushes the pipeline on exceptions detected in MEM. Its `stall` vector and `flush` line drive the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers.

## Interface
- `DIV_CYCLES`, default 34: EX-stage cycles a multi-cycle MDU operation occupies; minimum 2.
- `EXC_VECTOR`, default 32'h0000_0020: exception handler address driven on `new_pc`.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `stallreq_id` in 1: load-use hazard in ID.
- `ex_mdu_start` in 1: EX holds a multi-cycle MDU instruction. Single-cycle pulse, sampled in RUN only.
- `stallreq_mem` in 1: data memory not ready.
- `mem_excp` in 1: exception at MEM stage.
- `stall` out 6: hold bits. [0] PC, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb, [5] WB/regfile write.
- `flush` out 1: clear all pipeline registers this cycle.
- `new_pc` out 32: PC redirect target, valid only when `flush`=1, else 0.
- `mdu_busy` out 1: MDU sequence in progress.
- `mdu_done` out 1: MDU result valid in EX this cycle.

## Operation
- Internal state:
  - State register with values RUN, MDU and FLUSH.
  - Down-counter `cnt`, width $clog2(DIV_CYCLES).
- Outputs are combinational from state, `cnt` and inputs.
- Stall priority, highest first:
  - `mem_excp`: `stall`=0, `flush`=1, `new_pc`=EXC_VECTOR.
  - `stallreq_mem`: `stall`=6'b011111.
  - EX stall (MDU state with `cnt`≠0, or RUN with `ex_mdu_start`): `stall`=6'b001111.
  - `stallreq_id`: `stall`=6'b000111.
  - None of the above: `stall`=0.
- RUN:
  - `mem_excp` → FLUSH.
  - Else `ex_mdu_start` → MDU, `cnt`←DIV_CYCLES-1. This holds even when `stallreq_mem` is also asserted.
  - Else stay in RUN.
- MDU:
  - `mdu_busy`=1.
  - `cnt` decrements every cycle while nonzero, regardless of `stallreq_mem`.
  - At `cnt`=0: `mdu_done`=1 and the EX stall is released.
    - If `stallreq_mem`=0 → RUN.
    - If `stallreq_mem`=1, stay in MDU at `cnt`=0 with `mdu_done` held until `stallreq_mem` drops, then → RUN.
  - `ex_mdu_start` is ignored in MDU.
  - `mem_excp` in MDU aborts the sequence: `cnt`←0, `mdu_busy`=0 the same cycle, → FLUSH.
- FLUSH:
  - Lasts exactly one cycle.
  - `flush`=0, `stall`=0, and all request inputs are ignored (they come from squashed bubbles).
  - If `mem_excp` is asserted again in FLUSH, it is honoured: `flush`=1, stay in FLUSH.
  - Otherwise → RUN.
- Simultaneous `mem_excp` and `ex_mdu_start`: the exception wins and no MDU sequence starts.

## Timing
- Reset:
  - While `rst`=1, all outputs are 0.
  - On the next edge, state←RUN and `cnt`←0.
  - `rst` asserted mid-MDU aborts immediately; no `mdu_done` is emitted.
- Zero-latency control: `stall`, `flush` and `new_pc` respond in the same cycle as their inputs.
- MDU timeline, with `ex_mdu_start` at cycle T and no other requests:
  - `stall`=001111 in cycles T..T+DIV_CYCLES-1.
  - `mdu_busy`=1 in cycles T+1..T+DIV_CYCLES.
  - `mdu_done`=1 and `stall`=0 at T+DIV_CYCLES; RUN at T+DIV_CYCLES+1.
- Exception: `flush` is high for exactly the cycle `mem_excp` is seen; the following cycle is FLUSH.

## Structure
- The shared CPU package holds:
  - Stall-bit index constants: STALL_PC, STALL_IF, STALL_ID, STALL_EX, STALL_MEM, STALL_WB.
  - Stall vector constants: STALL_NONE, STALL_FROM_ID, STALL_FROM_EX, STALL_FROM_MEM.
  - The `pipe_ctrl_state_t` enum (RUN, MDU, FLUSH).
  - The default EXC_VECTOR.
- Single flat module; the counter is inline and has no sub-module.

## Test plan
- Reset asserted mid-MDU (`cnt`=10) → outputs 0 during `rst`; after release, RUN, and no `mdu_done` pulse ever appears.
- `ex_mdu_start` at T, DIV_CYCLES=34 → `stall`=6'h0F for 34 cycles, `mdu_done`=1 exactly at T+34 with `stall`=0.
- `stallreq_id`=1 alone → `stall`=6'h07. `stallreq_id`=1 with `stallreq_mem`=1 → `stall`=6'h1F.
- MDU reaches `cnt`=0 while `stallreq_mem`=1 for 3 cycles → `mdu_done` held 4 cycles, `stall`=6'h1F for 3 of them, then RUN.
- `mem_excp` at MDU `cnt`=5 → same cycle: `flush`=1, `new_pc`=32'h20, `stall`=0, `mdu_busy`=0. Next cycle FLUSH ignores `stallreq_id`=1 (`stall`=0).
- `mem_excp` and `ex_mdu_start` in the same RUN cycle → `flush`=1, no MDU entry, `mdu_busy` stays 0.
